// File: rtl/fu_ls_pipe.sv
// Buffered load/store unit: computes effective addresses, issues in order to the LSQ,
// extends load data and writes results back in program order.
module fu_ls_pipe #(
    parameter int XLEN       = 32,
    parameter int DEPTH      = 4,
    parameter int SQ_IDX_LEN = 3,
    parameter int TAG_LEN    = 6,
    localparam int PW        = $clog2(DEPTH),
    localparam int ID_W      = PW + 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  squash,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_is_store,
    input  logic [2:0]            in_funct3,
    input  logic [XLEN-1:0]       in_base,
    input  logic [XLEN-1:0]       in_imm,
    input  logic [XLEN-1:0]       in_data,
    input  logic [SQ_IDX_LEN-1:0] in_sq_pos,
    input  logic [TAG_LEN-1:0]    in_tag,
    output logic                  lsq_req_valid,
    input  logic                  lsq_req_ready,
    output logic                  lsq_req_store,
    output logic [XLEN-1:0]       lsq_req_addr,
    output logic [XLEN-1:0]       lsq_req_data,
    output logic [1:0]            lsq_req_size,
    output logic [SQ_IDX_LEN-1:0] lsq_req_sq_pos,
    output logic [ID_W-1:0]       lsq_req_id,
    input  logic                  lsq_resp_valid,
    input  logic [ID_W-1:0]       lsq_resp_id,
    input  logic [XLEN-1:0]       lsq_resp_data,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [TAG_LEN-1:0]    wb_tag,
    output logic [XLEN-1:0]       wb_value,
    output logic                  wb_is_store,
    output logic                  wb_misaligned,
    output logic [XLEN-1:0]       wb_addr,
    output logic [2*DEPTH-1:0]    dbg_state
);

    typedef enum logic [1:0] {S_IDLE, S_PEND, S_OUT, S_DONE} ent_state_t;

    localparam logic [PW:0] DEPTH_C = DEPTH[PW:0];

    ent_state_t            st     [DEPTH];
    logic                  e_store[DEPTH];
    logic [2:0]            e_f3   [DEPTH];
    logic [XLEN-1:0]       e_addr [DEPTH];
    logic [XLEN-1:0]       e_data [DEPTH];
    logic [SQ_IDX_LEN-1:0] e_sq   [DEPTH];
    logic [TAG_LEN-1:0]    e_tag  [DEPTH];
    logic                  e_mis  [DEPTH];
    logic [XLEN-1:0]       e_val  [DEPTH];

    logic [PW-1:0] tail_ptr, req_ptr, head_ptr;
    logic [PW:0]   count, pend_cnt;
    logic          epoch;

    logic            push, req_hs, req_skip, adv, pop, resp_hit;
    logic [PW-1:0]   resp_slot;
    logic [XLEN-1:0] enq_addr;
    logic            enq_mis;

    function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] w,
                                                input logic [1:0] a,
                                                input logic [2:0] f3);
        logic [XLEN-1:0] sh;
        sh = w >> {a, 3'b000};
        case (f3)
            3'b000:  extract = {{(XLEN-8){sh[7]}}, sh[7:0]};
            3'b001:  extract = {{(XLEN-16){sh[15]}}, sh[15:0]};
            3'b100:  extract = {{(XLEN-8){1'b0}}, sh[7:0]};
            3'b101:  extract = {{(XLEN-16){1'b0}}, sh[15:0]};
            default: extract = w;
        endcase
    endfunction

    // Every handshake transfers on a clock edge where valid && ready; a producer holds its
    // payload steady and keeps valid high until that edge, and valid never depends on ready.
    assign in_ready = (count < DEPTH_C) && !reset;

    assign enq_addr = in_base + in_imm;
    assign enq_mis  = (in_funct3[1:0] == 2'b01 && enq_addr[0]) ||
                      (in_funct3[1:0] == 2'b10 && enq_addr[1:0] != 2'b00);

    // pend_cnt tracks entries not yet passed by req, so a full buffer with req == head
    // is not mistaken for an unissued entry.
    assign lsq_req_valid = (pend_cnt != '0) && (st[req_ptr] == S_PEND);
    assign wb_valid      = (st[head_ptr] == S_DONE);

    assign resp_slot = lsq_resp_id[PW-1:0];
    assign push      = in_valid && in_ready && !squash;
    assign req_hs    = lsq_req_valid && lsq_req_ready && !squash;
    assign req_skip  = (pend_cnt != '0) && (st[req_ptr] == S_DONE) && !squash;
    assign adv       = req_hs || req_skip;
    assign pop       = wb_valid && wb_ready && !squash;
    assign resp_hit  = lsq_resp_valid && !squash && (lsq_resp_id[ID_W-1] == epoch) &&
                       (st[resp_slot] == S_OUT);

    assign lsq_req_store  = lsq_req_valid ? e_store[req_ptr] : 1'b0;
    assign lsq_req_addr   = lsq_req_valid ? e_addr[req_ptr] : '0;
    assign lsq_req_data   = lsq_req_valid ? e_data[req_ptr] : '0;
    assign lsq_req_size   = lsq_req_valid ? e_f3[req_ptr][1:0] : 2'b00;
    assign lsq_req_sq_pos = lsq_req_valid ? e_sq[req_ptr] : '0;
    assign lsq_req_id     = lsq_req_valid ? {epoch, req_ptr} : '0;

    assign wb_tag        = wb_valid ? e_tag[head_ptr] : '0;
    assign wb_value      = wb_valid ? e_val[head_ptr] : '0;
    assign wb_is_store   = wb_valid ? e_store[head_ptr] : 1'b0;
    assign wb_misaligned = wb_valid ? e_mis[head_ptr] : 1'b0;
    assign wb_addr       = wb_valid ? e_addr[head_ptr] : '0;

    always_comb begin
        dbg_state = '0;
        for (int i = 0; i < DEPTH; i++) dbg_state[2*i +: 2] = st[i];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                st[i]      <= S_IDLE;
                e_store[i] <= 1'b0;
                e_f3[i]    <= '0;
                e_addr[i]  <= '0;
                e_data[i]  <= '0;
                e_sq[i]    <= '0;
                e_tag[i]   <= '0;
                e_mis[i]   <= 1'b0;
                e_val[i]   <= '0;
            end
            tail_ptr <= '0;
            req_ptr  <= '0;
            head_ptr <= '0;
            count    <= '0;
            pend_cnt <= '0;
            epoch    <= 1'b0;
        end else if (squash) begin
            for (int i = 0; i < DEPTH; i++) st[i] <= S_IDLE;
            tail_ptr <= '0;
            req_ptr  <= '0;
            head_ptr <= '0;
            count    <= '0;
            pend_cnt <= '0;
            epoch    <= ~epoch;
        end else begin
            if (push) begin
                st[tail_ptr]      <= enq_mis ? S_DONE : S_PEND;
                e_store[tail_ptr] <= in_is_store;
                e_f3[tail_ptr]    <= in_funct3;
                e_addr[tail_ptr]  <= enq_addr;
                e_data[tail_ptr]  <= in_data;
                e_sq[tail_ptr]    <= in_sq_pos;
                e_tag[tail_ptr]   <= in_tag;
                e_mis[tail_ptr]   <= enq_mis;
                e_val[tail_ptr]   <= '0;
                tail_ptr          <= tail_ptr + PW'(1);
            end
            if (req_hs) st[req_ptr] <= e_store[req_ptr] ? S_DONE : S_OUT;
            if (adv) req_ptr <= req_ptr + PW'(1);
            if (resp_hit) begin
                st[resp_slot]    <= S_DONE;
                e_val[resp_slot] <= extract(lsq_resp_data, e_addr[resp_slot][1:0],
                                            e_f3[resp_slot]);
            end
            if (pop) begin
                st[head_ptr] <= S_IDLE;
                head_ptr     <= head_ptr + PW'(1);
            end
            count    <= count + (PW+1)'(push) - (PW+1)'(pop);
            pend_cnt <= pend_cnt + (PW+1)'(push) - (PW+1)'(adv);
        end
    end

endmodule
